// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: forwarding selects, load-use/branch/memory-wait stall and flush.
// Combinational outputs, sticky MemFault; optional perf counters under HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
`ifdef HAZARD_PERF_EN
  output logic [CNT_W-1:0] LoadUseCnt,
  output logic [CNT_W-1:0] MemWaitCnt,
`endif
  output logic             MemFault
);

  localparam int CW = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LIM = (MEM_TIMEOUT == 0) ? '0 : CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {S_RUN, S_WAIT, S_FAULT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic          mem_stall_raw;
  logic          mem_stall, lw_stall, lw_win, branch_win;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fault_d       = fault_q;
    mem_stall_raw = 1'b0;
    case (state_q)
      S_RUN: begin
        if (MemReqM && !MemReadyM) begin
          mem_stall_raw = 1'b1;
          state_d       = S_WAIT;
          cnt_d         = CW'(1);
        end
      end
      S_WAIT: begin
        // Ready releases the stall in the same cycle, even if MemReqM already dropped.
        if (MemReadyM) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          mem_stall_raw = 1'b1;
          if (MEM_TIMEOUT != 0 && cnt_q >= CNT_LIM) begin
            state_d = S_FAULT;
            fault_d = 1'b1;
          end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FAULT: mem_stall_raw = 1'b1;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    lw_stall   = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    mem_stall  = mem_stall_raw && !reset;
    branch_win = !reset && !mem_stall && PCSrcE;
    lw_win     = !reset && !mem_stall && !PCSrcE && lw_stall;

    ForwardAE = 2'b00;
    if (!reset) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
    end
    ForwardBE = 2'b00;
    if (!reset) begin
      if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
      else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
    end

    StallF = mem_stall || lw_win;
    StallD = mem_stall || lw_win;
    StallE = mem_stall;
    StallM = mem_stall;
    FlushD = branch_win;
    FlushE = branch_win || lw_win;
    FlushW = mem_stall;
  end

  assign MemFault = fault_q;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, mw_cnt_q, mw_cnt_d;

  always_comb begin
    lu_cnt_d = lu_cnt_q;
    mw_cnt_d = mw_cnt_q;
    if (lw_win && lu_cnt_q != '1)    lu_cnt_d = lu_cnt_q + 1'b1;
    if (mem_stall && mw_cnt_q != '1) mw_cnt_d = mw_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lu_cnt_q <= '0;
      mw_cnt_q <= '0;
    end else begin
      lu_cnt_q <= lu_cnt_d;
      mw_cnt_q <= mw_cnt_d;
    end
  end

  assign LoadUseCnt = lu_cnt_q;
  assign MemWaitCnt = mw_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, multi-cycle sequences, random run against a reference model.
module tb_pipeline_hazard_ctrl;
  localparam int T = 4;

  logic clock = 1'b0;
  logic reset;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault;
`ifdef HAZARD_PERF_EN
  logic [15:0] LoadUseCnt, MemWaitCnt;
`endif
  logic [11:0] outs;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
`ifdef HAZARD_PERF_EN
    .LoadUseCnt(LoadUseCnt), .MemWaitCnt(MemWaitCnt),
`endif
    .MemFault(MemFault)
  );

  // {FA, FB, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault}
  assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemFault};

  typedef struct {
    string      name;
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rsrc;
    logic       rwm, rww, pc, req, rdy;
    logic [11:0] exp;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];
  int total = 0;
  int bad = 0;

  bit m_busy, m_fault;
  int m_n, m_lu, m_mw;

  function automatic vec_t mk(string n, logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
                              logic [1:0] rsrc, logic rwm, rww, pc, req, rdy, logic [11:0] e);
    vec_t v;
    v.name = n; v.rs1d = rs1d; v.rs2d = rs2d; v.rs1e = rs1e; v.rs2e = rs2e;
    v.rde = rde; v.rdm = rdm; v.rdw = rdw; v.rsrc = rsrc;
    v.rwm = rwm; v.rww = rww; v.pc = pc; v.req = req; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
  endtask

  task automatic model_clear();
    m_busy = 0; m_fault = 0; m_n = 0; m_lu = 0; m_mw = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic step_check(string nm, logic [11:0] e);
    @(negedge clock);
    check(nm, {20'd0, outs}, {20'd0, e});
    @(posedge clock); #1;
  endtask

  function automatic logic [1:0] fwd_ref(logic [4:0] rs);
    if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
    if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    logic [11:0] e;
    bit lw, ms;
    vecs[0]  = mk("fwdA_M_prio", 0,0,5,0,0,5,5, 2'b00, 1,1,0,0,0, 12'b10_00_0000_000_0);
    vecs[1]  = mk("fwdA_W",      0,0,5,0,0,5,5, 2'b00, 0,1,0,0,0, 12'b01_00_0000_000_0);
    vecs[2]  = mk("fwd_zero",    0,0,0,0,0,0,0, 2'b00, 1,1,0,0,0, 12'b00_00_0000_000_0);
    vecs[3]  = mk("fwdB_M",      0,0,0,7,0,7,7, 2'b00, 1,1,0,0,0, 12'b00_10_0000_000_0);
    vecs[4]  = mk("fwdAB_W",     0,0,9,9,0,9,9, 2'b00, 0,1,0,0,0, 12'b01_01_0000_000_0);
    vecs[5]  = mk("lu_rs2",      0,3,0,0,3,0,0, 2'b01, 0,0,0,0,0, 12'b00_00_1100_010_0);
    vecs[6]  = mk("lu_rs1",      3,0,0,0,3,0,0, 2'b01, 0,0,0,0,0, 12'b00_00_1100_010_0);
    vecs[7]  = mk("lu_rd0",      0,0,0,0,0,0,0, 2'b01, 0,0,0,0,0, 12'b00_00_0000_000_0);
    vecs[8]  = mk("not_load",    3,0,0,0,3,0,0, 2'b10, 0,0,0,0,0, 12'b00_00_0000_000_0);
    vecs[9]  = mk("br_over_lu",  3,0,0,0,3,0,0, 2'b01, 0,0,1,0,0, 12'b00_00_0000_110_0);
    vecs[10] = mk("branch",      0,0,0,0,0,0,0, 2'b00, 0,0,1,0,0, 12'b00_00_0000_110_0);
    vecs[11] = mk("mem_rdy_run", 0,0,0,0,0,0,0, 2'b00, 0,0,0,1,1, 12'b00_00_0000_000_0);
    vecs[12] = mk("mem_beats_all",3,0,4,0,3,4,0, 2'b01, 1,0,1,1,0, 12'b10_00_1111_001_0);
    vecs[13] = mk("mem_release", 0,0,0,4,0,0,4, 2'b00, 0,1,0,1,1, 12'b00_01_0000_000_0);

    idle_inputs();
    model_clear();
    reset = 1'b1;
    #1 check("reset_state", {20'd0, outs}, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
      RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw; ResultSrcE = vecs[i].rsrc;
      RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pc;
      MemReqM = vecs[i].req; MemReadyM = vecs[i].rdy;
      step_check(vecs[i].name, vecs[i].exp);
    end

    // Load-use: one bubble, then the bubble in Execute clears the hazard.
    do_reset();
    ResultSrcE = 2'b01; RdE = 3; Rs2D = 3;
    step_check("lu_seq_stall", 12'b00_00_1100_010_0);
    ResultSrcE = 2'b00; RdE = 0;
    step_check("lu_seq_bubble", 12'b0);
`ifdef HAZARD_PERF_EN
    check("lu_cnt", {16'd0, LoadUseCnt}, 32'd1);
`endif

    // Memory wait: three not-ready cycles, released in the ready cycle.
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int k = 0; k < 3; k++) step_check($sformatf("mw_stall%0d", k), 12'b00_00_1111_001_0);
    MemReadyM = 1;
    step_check("mw_ready", 12'b0);
`ifdef HAZARD_PERF_EN
    check("mw_cnt", {16'd0, MemWaitCnt}, 32'd3);
`endif
    MemReqM = 0; MemReadyM = 0;
    step_check("mw_idle", 12'b0);

    // Timeout: fault after the T-th stalled cycle, ready ignored, cleared by reset.
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int k = 0; k < T; k++) step_check($sformatf("to_stall%0d", k), 12'b00_00_1111_001_0);
    step_check("to_fault", 12'b00_00_1111_001_1);
    MemReadyM = 1;
    step_check("to_rdy_ignored0", 12'b00_00_1111_001_1);
    step_check("to_rdy_ignored1", 12'b00_00_1111_001_1);
    reset = 1'b1;
    #1 check("to_reset_clears", {20'd0, outs}, 32'd0);
    MemReqM = 0; MemReadyM = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    step_check("to_after_reset", 12'b0);

    // Reset asserted during the second wait cycle.
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    step_check("rmw_first", 12'b00_00_1111_001_0);
    @(negedge clock);
    check("rmw_wait", {20'd0, outs}, {20'd0, 12'b00_00_1111_001_0});
    reset = 1'b1;
    #1 check("rmw_in_reset", {20'd0, outs}, 32'd0);
    MemReqM = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    step_check("rmw_idle", 12'b0);
    // Counter was cleared: a fresh access needs T full stall cycles before faulting.
    MemReqM = 1;
    for (int k = 0; k < T; k++) step_check($sformatf("rmw_fresh%0d", k), 12'b00_00_1111_001_0);
    step_check("rmw_fault", 12'b00_00_1111_001_1);

    // Random run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b1;
        #1 check("rand_reset", {20'd0, outs}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        model_clear();
        continue;
      end
      Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
      Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
      RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
      RdW  = 5'($urandom_range(0, 7)); ResultSrcE = 2'($urandom_range(0, 3));
      RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
      PCSrcE = ($urandom_range(0, 7) == 0);
      MemReqM = 1'($urandom_range(0, 1));
      MemReadyM = ($urandom_range(0, 9) < 6);
      @(negedge clock);
      lw = (ResultSrcE == 2'b01) && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
      ms = m_fault || (m_busy ? !MemReadyM : (MemReqM && !MemReadyM));
      e = {fwd_ref(Rs1E), fwd_ref(Rs2E),
           ms | (!PCSrcE & lw), ms | (!PCSrcE & lw), ms, ms,
           !ms & PCSrcE, !ms & (PCSrcE | lw), ms, m_fault};
      check("rand_outs", {20'd0, outs}, {20'd0, e});
`ifdef HAZARD_PERF_EN
      check("rand_lu_cnt", {16'd0, LoadUseCnt}, 32'(m_lu));
      check("rand_mw_cnt", {16'd0, MemWaitCnt}, 32'(m_mw));
`endif
      if (!m_fault) begin
        if (ms) begin
          m_busy = 1; m_n++;
          if (m_n == T) m_fault = 1;
        end else begin
          m_busy = 0; m_n = 0;
        end
      end
      if (!ms && !PCSrcE && lw) m_lu++;
      if (ms) m_mw++;
      @(posedge clock); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage RISC-V pipeline. It drives the enable/flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage forwarding mux selects. It covers four hazard classes:
- load-use stalls
- branch flushes
- RAW forwarding
- multi-cycle data-memory wait states, via a small FSM with a timeout fault.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for MemReadyM before fault; 0 disables the timeout.
CNT_W, 16, width of the optional performance counters.

Ports:
clock  input  1  pipeline clock
reset  input  1  asynchronous, active-high
Rs1D  input  5  rs1 of instruction in Decode
Rs2D  input  5  rs2 of instruction in Decode
Rs1E  input  5  rs1 of instruction in Execute
Rs2E  input  5  rs2 of instruction in Execute
RdE  input  5  rd in Execute
RdM  input  5  rd in Memory
RdW  input  5  rd in Writeback
ResultSrcE  input  2  result select in Execute; 2'b01 = load
RegWriteM  input  1  register write in Memory
RegWriteW  input  1  register write in Writeback
PCSrcE  input  1  branch/jump taken, resolved in Execute
MemReqM  input  1  load or store active in Memory
MemReadyM  input  1  data memory completes access this cycle
ForwardAE  output  2  src A select: 00 regfile, 01 Writeback result, 10 ALUResultM
ForwardBE  output  2  src B select, same encoding
StallF  output  1  hold PC
StallD  output  1  hold IF/ID
StallE  output  1  hold ID/EX
StallM  output  1  hold EX/MEM (drives its enable low)
FlushD  output  1  clear IF/ID
FlushE  output  1  clear ID/EX
FlushW  output  1  clear MEM/WB (inject bubble)
MemFault  output  1  sticky memory timeout flag

Behaviour:
- Reset is asynchronous and active-high; clock is clock.
- While reset is high:
  - FSM is in RUN, wait counter = 0, MemFault = 0.
  - Forward* = 00, all Stall* = 0, all Flush* = 0 (pipeline registers clear on their own reset).
- All outputs except MemFault are combinational from the current inputs and FSM state.

Forwarding (evaluated every cycle, including stalls):
- ForwardAE = 10 if RegWriteM & RdM≠0 & RdM==Rs1E.
- Otherwise 01 if RegWriteW & RdW≠0 & RdW==Rs1E.
- Otherwise 00.
- Memory stage has priority over Writeback. ForwardBE is computed the same way using Rs2E.

Internal conditions:
- lwStall = (ResultSrcE==01) & RdE≠0 & (RdE==Rs1D | RdE==Rs2D).
- memStall = (state==RUN & MemReqM & ~MemReadyM) | state==WAIT | state==FAULT.

Priority, highest first:
1. memStall:
   - StallF = StallD = StallE = StallM = 1, FlushW = 1.
   - FlushD = FlushE = 0; lwStall and PCSrcE are ignored (the E/D contents stay frozen and are re-evaluated once the wait ends).
2. PCSrcE:
   - FlushD = FlushE = 1, StallF = StallD = 0.
   - The branch beats lwStall, because the Decode instruction is on the wrong path.
3. lwStall:
   - StallF = StallD = 1, FlushE = 1.
   - Exactly one bubble is inserted per load-use pair.
4. Otherwise all Stall*/Flush* = 0.

FSM:
- RUN:
  - MemReqM & ~MemReadyM → WAIT, counter ← 1.
  - Else stay in RUN.
- WAIT:
  - MemReadyM → RUN, counter ← 0. The stall releases in that same cycle, so the access completes with 0 extra cycles after ready.
  - Else if MEM_TIMEOUT≠0 and counter==MEM_TIMEOUT-1 → FAULT, MemFault ← 1.
  - Else counter + 1.
- FAULT:
  - Pipeline stays frozen (memStall = 1) and MemFault holds at 1 until reset.
  - MemReadyM is ignored.
- Counter width is clog2(MEM_TIMEOUT+1); with MEM_TIMEOUT = 0 the counter saturates instead of wrapping.
- Reset asserted mid-WAIT returns to RUN immediately and clears the counter and MemFault.
- MemReqM deasserting while in WAIT is a protocol error; the FSM keeps waiting for MemReadyM.

Optional Feature:
Macro: HAZARD_PERF_EN
- Defined:
  - Adds outputs LoadUseCnt [CNT_W-1:0] and MemWaitCnt [CNT_W-1:0].
  - LoadUseCnt increments on each cycle where lwStall is the winning condition.
  - MemWaitCnt increments on each cycle where memStall = 1.
  - Both counters saturate at all-ones and reset asynchronously to 0.
- Not defined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Forwarding priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 → ForwardAE = 10. Then RegWriteM = 0 → 01. Then Rs1E = 0 with RdM = RdW = 0 → 00.
- Load-use: ResultSrcE = 01, RdE = 3, Rs2D = 3, MemReqM = 0 → StallF = StallD = FlushE = 1 for exactly 1 cycle. Next cycle (RdE = 0, bubble) all stalls = 0. With HAZARD_PERF_EN, LoadUseCnt = 1.
- Branch vs load-use: PCSrcE = 1 and lwStall condition true in the same cycle → FlushD = FlushE = 1, StallF = StallD = 0.
- Memory wait: MemReqM = 1, MemReadyM low for 3 cycles then high → StallF/D/E/M = FlushW = 1 for 3 cycles, 0 in the ready cycle, FSM back to RUN. With HAZARD_PERF_EN, MemWaitCnt = 3.
- Timeout: MEM_TIMEOUT = 4, MemReqM = 1, MemReadyM held 0 → MemFault rises after the 4th stalled cycle and stays 1. A later MemReadyM = 1 has no effect. Pulsing reset clears MemFault and all stalls drop.
- Reset mid-WAIT: assert reset in the 2nd wait cycle → stalls = 0 while reset is high. After release with MemReqM = 0, outputs are idle (all 0).
